// File: rtl/vram_pkg.sv
// vram_pkg: constants and types shared by the VRAM writer and reader sides.
package vram_pkg;

    localparam int H_TIME_DEF = 794;   // VRAM columns per row
    localparam int V_TIME_DEF = 523;   // VRAM rows
    localparam int COORD_W    = 11;

    typedef logic [COORD_W-1:0] coord_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_FIN  = 2'd2
    } state_t;

endpackage

// File: rtl/vram_raster_counter.sv
// vram_raster_counter: row-major rectangle scanner. Load captures the
// rectangle bounds and starts at its top-left cell; each step moves one
// column right, wrapping to the first column of the next row. o_last flags
// the bottom-right cell so the caller never steps past it.
module vram_raster_counter
    import vram_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_load,
    input  logic        i_step,
    input  logic [10:0] i_row_ini,
    input  logic [10:0] i_row_fin,
    input  logic [10:0] i_col_ini,
    input  logic [10:0] i_col_fin,
    output logic [10:0] o_row,
    output logic [10:0] o_col,
    output logic        o_last
);

    coord_t r_row;
    coord_t r_col;
    coord_t r_col_ini;
    coord_t r_row_fin;
    coord_t r_col_fin;

    // Bound capture on load, raster advance on step; hold otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_row     <= '0;
            r_col     <= '0;
            r_col_ini <= '0;
            r_row_fin <= '0;
            r_col_fin <= '0;
        end else if (i_load) begin
            r_row     <= i_row_ini;
            r_col     <= i_col_ini;
            r_col_ini <= i_col_ini;
            r_row_fin <= i_row_fin;
            r_col_fin <= i_col_fin;
        end else if (i_step) begin
            if (r_col == r_col_fin) begin
                r_col <= r_col_ini;
                r_row <= r_row + 11'd1;
            end else begin
                r_col <= r_col + 11'd1;
            end
        end
    end

    assign o_row  = r_row;
    assign o_col  = r_col;
    assign o_last = (r_row == r_row_fin) && (r_col == r_col_fin);

endmodule

// File: rtl/vram_writer.sv
// vram_writer: fills a rectangle of VRAM with a single pixel value, one
// write per clock in row-major order. Commands are validated against the
// VRAM size before being accepted.
// Optional build macro VRAM_WRITER_CLIP_EN: clamp out-of-range end
// coordinates to the VRAM edge instead of rejecting the command.
module vram_writer
    import vram_pkg::*;
#(
    parameter int HTime = H_TIME_DEF,
    parameter int VTime = V_TIME_DEF
)(
    input  logic        clk,
    input  logic        rst,
    input  logic        Start,
    input  logic [10:0] FilaIni,
    input  logic [10:0] FilaFin,
    input  logic [10:0] ColumnaIni,
    input  logic [10:0] ColumnaFin,
    input  logic        Color,
    input  logic        Abort,
    output logic        WrEn,
    output logic [10:0] WrFila,
    output logic [10:0] WrColumna,
    output logic        WrPixel,
    output logic        Busy,
    output logic        Done,
    output logic        Error
);

    localparam coord_t H_MAX = coord_t'(HTime - 1);
    localparam coord_t V_MAX = coord_t'(VTime - 1);

    state_t r_state;
    state_t w_state_nx;
    logic   r_error;
    logic   r_color;
    logic   w_load;
    logic   w_step;
    logic   w_err_set;
    logic   w_last;
    logic   w_range_bad;
    logic   w_valid;
    coord_t w_fila_fin;
    coord_t w_col_fin;
    coord_t w_row;
    coord_t w_col;

`ifdef VRAM_WRITER_CLIP_EN
    assign w_fila_fin  = (FilaFin    > V_MAX) ? V_MAX : FilaFin;
    assign w_col_fin   = (ColumnaFin > H_MAX) ? H_MAX : ColumnaFin;
    assign w_range_bad = (FilaIni > V_MAX) || (ColumnaIni > H_MAX);
`else
    assign w_fila_fin  = FilaFin;
    assign w_col_fin   = ColumnaFin;
    // Ini beyond the edge is caught by the Ini<=Fin test below.
    assign w_range_bad = (FilaFin > V_MAX) || (ColumnaFin > H_MAX);
`endif

    assign w_valid = !w_range_bad && (FilaIni <= w_fila_fin) && (ColumnaIni <= w_col_fin);

    vram_raster_counter u_raster (
        .clk       (clk),
        .rst       (rst),
        .i_load    (w_load),
        .i_step    (w_step),
        .i_row_ini (FilaIni),
        .i_row_fin (w_fila_fin),
        .i_col_ini (ColumnaIni),
        .i_col_fin (w_col_fin),
        .o_row     (w_row),
        .o_col     (w_col),
        .o_last    (w_last)
    );

    // State register, error pulse and latched colour.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_error <= 1'b0;
            r_color <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_error <= w_err_set;
            if (w_load) begin
                r_color <= Color;
            end
        end
    end

    // Next state and counter control; Abort outranks the last-cell exit.
    always_comb begin
        w_state_nx = r_state;
        w_load     = 1'b0;
        w_step     = 1'b0;
        w_err_set  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (Start) begin
                    if (w_valid) begin
                        w_load     = 1'b1;
                        w_state_nx = S_FILL;
                    end else begin
                        w_err_set  = 1'b1;
                    end
                end
            end
            S_FILL: begin
                if (Abort) begin
                    w_state_nx = S_IDLE;
                end else if (w_last) begin
                    w_state_nx = S_FIN;
                end else begin
                    w_step     = 1'b1;
                end
            end
            S_FIN: begin
                w_state_nx = S_IDLE;
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    // The counter registers double as the write address; they hold their
    // last value whenever the FSM leaves FILL.
    assign WrEn      = (r_state == S_FILL);
    assign Busy      = (r_state == S_FILL);
    assign Done      = (r_state == S_FIN);
    assign Error     = r_error;
    assign WrFila    = w_row;
    assign WrColumna = w_col;
    assign WrPixel   = r_color;

endmodule
